sgfilter_seq: RTL and testbench

SGFILTER_SEQ -- requirements
Module: sgfilter_seq

---
 rtl/sgfilter_pkg.sv | 14 +
 rtl/sgfilter_seq_fifo.sv | 54 +++++
 rtl/sgfilter_seq.sv | 130 +++++++++++++
 tb/tb_sgfilter_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgfilter_pkg.sv
// Shared types and default sizes for the sgfilter call sequencer.
package sgfilter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/sgfilter_seq_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module sgfilter_seq_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        count_o = count_q;
        // Head is masked while empty so stale entries never leak out.
        pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sgfilter_seq.sv
// Sequences a run of sgfilter calls over consecutive idx values, buffers the
// results and streams them out while accumulating a wrapping checksum.
//
// state | meaning
// IDLE  | waiting for go; checksum holds the last run's value
// ISSUE | issuing calls under the inflight+buffered credit limit
// DRAIN | all calls accepted; waiting for every result to be streamed out
// FIN   | one-cycle run_done pulse
module sgfilter_seq
    import sgfilter_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] base_idx,
    input  logic [DATA_W-1:0] count,
    output logic              run_busy,
    output logic              run_done,
    output logic [DATA_W-1:0] checksum,
    output logic              call_start,
    input  logic              call_busy,
    output logic [DATA_W-1:0] call_idx,
    input  logic              ret_valid,
    output logic              ret_stall,
    input  logic [DATA_W-1:0] ret_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] issued_q;
    logic [DATA_W-1:0] received_q;
    logic [DATA_W-1:0] popped_q;
    logic [DATA_W-1:0] checksum_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] inflight;
    logic              credit_ok;
    logic              call_acc;
    logic              push;
    logic              pop;

    always_comb begin
        inflight   = issued_q - received_q;
        // Buffered plus outstanding results never exceed the FIFO depth,
        // so every returning result always has a slot.
        credit_ok  = (inflight + DATA_W'(fifo_count)) < DATA_W'(DEPTH);
        call_start = (state_q == ISSUE) && (issued_q < count_q) && credit_ok;
        call_idx   = base_q + issued_q;
        call_acc   = call_start && !call_busy;
        ret_stall  = fifo_full;
        push       = ret_valid && !fifo_full && ((state_q == ISSUE) || (state_q == DRAIN));
        out_valid  = !fifo_empty;
        pop        = out_valid && out_ready;
        out_last   = out_valid && (popped_q == count_q - DATA_W'(1));
        run_busy   = (state_q != IDLE);
        run_done   = (state_q == FIN);
        checksum   = checksum_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            received_q <= '0;
            popped_q   <= '0;
            checksum_q <= '0;
        end else begin
            if (call_acc) issued_q <= issued_q + DATA_W'(1);
            if (push) begin
                received_q <= received_q + DATA_W'(1);
                checksum_q <= checksum_q + ret_data;
            end
            if (pop) popped_q <= popped_q + DATA_W'(1);

            case (state_q)
                IDLE: begin
                    if (go) begin
                        base_q     <= base_idx;
                        count_q    <= count;
                        issued_q   <= '0;
                        received_q <= '0;
                        popped_q   <= '0;
                        checksum_q <= '0;
                        state_q    <= (count == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (call_acc && (issued_q + DATA_W'(1) == count_q)) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (popped_q == count_q) state_q <= FIN;
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sgfilter_seq_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clock_i    (clock),
        .reset_i    (reset),
        .push_i     (push),
        .push_data_i(ret_data),
        .pop_i      (pop),
        .pop_data_o (out_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_sgfilter_seq.sv
// Scoreboard bench for sgfilter_seq with a zero-latency sgfilter model.
module tb_sgfilter_seq;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          go;
    logic [DW-1:0] base_idx;
    logic [DW-1:0] count;
    logic          run_busy;
    logic          run_done;
    logic [DW-1:0] checksum;
    logic          call_start;
    logic          call_busy;
    logic [DW-1:0] call_idx;
    logic          ret_valid;
    logic          ret_stall;
    logic [DW-1:0] ret_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    sgfilter_seq #(.DEPTH(4), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .base_idx  (base_idx),
        .count     (count),
        .run_busy  (run_busy),
        .run_done  (run_done),
        .checksum  (checksum),
        .call_start(call_start),
        .call_busy (call_busy),
        .call_idx  (call_idx),
        .ret_valid (ret_valid),
        .ret_stall (ret_stall),
        .ret_data  (ret_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_idx_q [$];
    logic [DW-1:0] exp_out_q [$];
    logic [DW-1:0] pend_q    [$];
    logic [DW-1:0] exp_sum = '0;
    logic [DW-1:0] hold_idx = '0;
    logic [DW-1:0] ovr [2];
    int calls_acc = 0, beats = 0, done_cnt = 0, run_count = 0;
    int busy_at = -1, busy_left = 0, stall_seen = 0;
    bit model_en = 1'b1, ret_taken = 1'b0, hold_pend = 1'b0, ovr_en = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] res_of(input logic [DW-1:0] idx);
        return idx * 32'h0000_9E37 + 32'd7;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // sgfilter model drives after each edge; monitor samples on the falling edge.
    initial begin
        logic [DW-1:0] e;
        logic [DW-1:0] rv;
        forever begin
            @(posedge clock);
            #1;
            if (ret_taken && pend_q.size() > 0) void'(pend_q.pop_front());
            ret_taken = 1'b0;
            if (model_en) begin
                if (pend_q.size() > 0) begin
                    ret_valid = 1'b1;
                    ret_data  = pend_q[0];
                end else begin
                    ret_valid = 1'b0;
                    ret_data  = '0;
                end
            end
            call_busy = (calls_acc == busy_at) && (busy_left > 0);

            @(negedge clock);
            if (hold_pend) begin
                chk("hold_start", call_start, 1);
                chk("hold_idx", call_idx, hold_idx);
            end
            hold_pend = call_start && call_busy;
            hold_idx  = call_idx;
            if (call_start && call_busy) begin
                stall_seen++;
                if (busy_left > 0) busy_left--;
            end
            if (call_start && !call_busy) begin
                if (exp_idx_q.size() == 0) begin
                    chk("extra_call", DW'(calls_acc + 1), DW'(run_count));
                end else begin
                    e = exp_idx_q.pop_front();
                    chk("call_idx", call_idx, e);
                    rv = (ovr_en && calls_acc < 2) ? ovr[calls_acc] : res_of(e);
                    pend_q.push_back(rv);
                    exp_out_q.push_back(rv);
                    exp_sum = exp_sum + rv;
                end
                calls_acc++;
            end
            ret_taken = model_en && ret_valid && !ret_stall;
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) begin
                    chk("extra_beat", DW'(beats + 1), DW'(run_count));
                end else begin
                    chk("out_data", out_data, exp_out_q.pop_front());
                    chk("out_last", out_last, DW'(beats == run_count - 1));
                end
                beats++;
            end
            if (run_done) done_cnt++;
        end
    end

    task automatic start_run(input logic [DW-1:0] b, input logic [DW-1:0] c);
        for (int i = 0; i < int'(c); i++) exp_idx_q.push_back(b + DW'(i));
        run_count  = int'(c);
        calls_acc  = 0;
        beats      = 0;
        done_cnt   = 0;
        stall_seen = 0;
        exp_sum    = '0;
        base_idx   = b;
        count      = c;
        go         = 1'b1;
        tick();
        go = 1'b0;
        chk("run_busy_go", run_busy, 1);
        if (c != '0) chk("start_lat", call_start, 1);
        else         chk("done_lat", run_done, 1);
    endtask

    task automatic finish_run(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        tick(3);
        chk("run_done_cnt", DW'(done_cnt), 1);
        chk("beats", DW'(beats), DW'(run_count));
        chk("calls", DW'(calls_acc), DW'(run_count));
        chk("checksum", checksum, exp_sum);
        chk("idx_left", DW'(exp_idx_q.size()), 0);
        chk("idle_after", run_busy, 0);
    endtask

    initial begin
        int d;
        reset = 1'b1; go = 1'b0; base_idx = '0; count = '0;
        call_busy = 1'b0; ret_valid = 1'b0; ret_data = '0; out_ready = 1'b1;
        tick(2);
        chk("rst_call_start", call_start, 0);
        chk("rst_ret_stall", ret_stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_run_busy", run_busy, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_call_idx", call_idx, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_checksum", checksum, 0);
        reset = 1'b0;
        tick();

        // basic run
        start_run(32'd10, 32'd5);
        finish_run(100);

        // backpressure: credit limit stops issue at FIFO depth; go ignored while busy
        out_ready = 1'b0;
        start_run(32'd200, 32'd8);
        tick(20);
        chk("credit_calls", DW'(calls_acc), 4);
        chk("credit_stall", call_start, 0);
        chk("fifo_full_stall", ret_stall, 1);
        chk("full_out_valid", out_valid, 1);
        base_idx = 32'd999; count = 32'd3; go = 1'b1;
        tick();
        go = 1'b0;
        tick(2);
        chk("go_ignored", DW'(calls_acc), 4);
        out_ready = 1'b1;
        finish_run(200);

        // callee stall on the second call
        busy_at = 1; busy_left = 3;
        start_run(32'd100, 32'd4);
        finish_run(100);
        chk("stall_cycles", DW'(stall_seen), 3);
        busy_at = -1;

        // empty run
        start_run(32'd50, 32'd0);
        tick();
        chk("zero_done_end", run_done, 0);
        chk("zero_idle", run_busy, 0);
        finish_run(10);

        // checksum wraparound, then stray returns in IDLE ignored
        ovr[0] = 32'hFFFF_FFFF; ovr[1] = 32'h0000_0002; ovr_en = 1'b1;
        start_run(32'd7, 32'd2);
        finish_run(100);
        chk("checksum_wrap", checksum, 32'h1);
        ovr_en = 1'b0;
        model_en = 1'b0; ret_valid = 1'b1; ret_data = 32'h55;
        tick(3);
        ret_valid = 1'b0; ret_data = '0; model_en = 1'b1;
        tick();
        chk("idle_ret_sum", checksum, 32'h1);
        chk("idle_ret_out", out_valid, 0);

        // reset mid-run, then a fresh run
        start_run(32'd300, 32'd6);
        for (int i = 0; i < 100 && calls_acc < 3; i++) tick();
        chk("mid_calls_reached", DW'(calls_acc >= 3), 1);
        d = done_cnt;
        reset = 1'b1;
        tick();
        chk("rst_mid_idle", run_busy, 0);
        chk("rst_mid_outv", out_valid, 0);
        chk("rst_mid_start", call_start, 0);
        reset = 1'b0;
        #1;
        exp_idx_q.delete(); exp_out_q.delete(); pend_q.delete();
        ret_valid = 1'b0; ret_data = '0; ret_taken = 1'b0; hold_pend = 1'b0;
        tick(5);
        chk("rst_no_done", DW'(done_cnt), DW'(d));
        start_run(32'd40, 32'd2);
        finish_run(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
